execute_br_redirect: RTL and testbench

- Branch-resolution sequencer at the EXE stage.
- Instantiates the branch-destination datapath and registers the computed target when a branch resolves taken.
- Presents the target to fetch as a held redirect request (valid/ack) and tracks a 2-bit fetch generation so wrong-path instructions are annulled.
- Arbitrates between branch redirects and exception-vector redirects; exceptions always win.

---
 rtl/execute_br_redirect_pkg.sv | 26 ++
 rtl/execute_br_redirect_dest.sv | 57 +++++
 rtl/execute_br_redirect.sv | 129 ++++++++++++
 tb/tb_execute_br_redirect.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_br_redirect_pkg.sv
// Shared definitions for the EXE-stage branch redirect slice: datapath width,
// fetch generation width, branch-destination select encodings and the
// redirect controller state type.
package execute_br_redirect_pkg;

   // Architectural datapath width.
   localparam int unsigned REGSZ = 32;

   // Width of the fetch generation tag used to annul wrong-path instructions.
   localparam int unsigned FETCH_GENW = 2;

   // Branch destination select carried by the EXE instruction.
   typedef enum logic [1:0] {
      EXOP_BR_DEST_NONE    = 2'd0,  // not a branch
      EXOP_BR_DEST_A       = 2'd1,  // target = operand A
      EXOP_BR_DEST_C       = 2'd2,  // target = operand C (LR/CTR)
      EXOP_BR_DEST_PC_A_AA = 2'd3   // target = AA ? A : PC + A
   } brdest_op_e;

   // Redirect controller states.
   typedef enum logic {
      ST_IDLE = 1'b0,  // no redirect outstanding
      ST_REQ  = 1'b1   // redirect presented to fetch, waiting for ack
   } redir_state_e;

endpackage : execute_br_redirect_pkg

// File: rtl/execute_br_redirect_dest.sv
// Branch-destination datapath: selects the branch target from operand A,
// operand C or a PC-relative sum, and word-aligns the result. Purely
// combinational; the output is forced to zero when no instruction is valid.
module execute_br_dest
   import execute_br_redirect_pkg::*;
#(
   parameter int unsigned REGSZ_P = REGSZ
) (
   input  logic               clk,
   input  logic [1:0]         brdest_op,
   input  logic [REGSZ_P-1:0] op_a,
   input  logic [REGSZ_P-1:0] op_c,
   input  logic [REGSZ_P-1:0] pc,
   input  logic               inst_aa,
   input  logic               input_valid,
   output logic [REGSZ_P-1:0] br_dest
);

   // Clears the two low bits so every target is a word address.
   localparam logic [REGSZ_P-1:0] ALIGN_MASK = ~(REGSZ_P'(3));

   logic [REGSZ_P-1:0] pc_rel;
   logic [REGSZ_P-1:0] raw_dest;

   // Select the raw target; PC-relative add wraps modulo 2^REGSZ.
   always_comb begin
      pc_rel   = pc + op_a;
      raw_dest = '0;
      unique case (brdest_op_e'(brdest_op))
         EXOP_BR_DEST_A:       raw_dest = op_a;
         EXOP_BR_DEST_C:       raw_dest = op_c;
         EXOP_BR_DEST_PC_A_AA: raw_dest = inst_aa ? op_a : pc_rel;
         default:              raw_dest = '0;
      endcase
   end

   // Word-align and gate with instruction valid.
   always_comb begin
      br_dest = '0;
      if (input_valid) begin
         br_dest = raw_dest & ALIGN_MASK;
      end
   end

`ifdef SIM
   // Flag an undefined select on a valid instruction.
   always @(posedge clk) begin
      if (input_valid && $isunknown(brdest_op)) begin
         $fatal(1, "execute_br_dest: unknown brdest_op with input_valid");
      end
   end
`else
   logic unused_clk;
   assign unused_clk = clk;
`endif

endmodule : execute_br_dest

// File: rtl/execute_br_redirect.sv
// EXE-stage branch resolution sequencer. Registers the resolved target of a
// taken branch (or an exception vector) and presents it to fetch as a held
// valid/ack redirect request. Each redirect bumps a small fetch generation
// tag; EXE instructions carrying a stale tag are annulled. Exceptions always
// take priority over branches and may overwrite an outstanding request.
module execute_br_redirect
   import execute_br_redirect_pkg::*;
#(
   parameter int unsigned REGSZ = execute_br_redirect_pkg::REGSZ,
   parameter int unsigned GENW  = FETCH_GENW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             input_valid,
   input  logic [GENW-1:0]  in_gen,
   input  logic [1:0]       brdest_op,
   input  logic [REGSZ-1:0] op_a,
   input  logic [REGSZ-1:0] op_c,
   input  logic [REGSZ-1:0] pc,
   input  logic             inst_aa,
   input  logic             br_taken,
   input  logic             exc_valid,
   input  logic [REGSZ-1:0] exc_vector,
   output logic             redirect_valid,
   output logic [REGSZ-1:0] redirect_pc,
   input  logic             redirect_ack,
   output logic [GENW-1:0]  cur_gen,
   output logic             exe_stall,
   output logic             annul,
   output logic [15:0]      redirect_count
);

   localparam logic [REGSZ-1:0] ALIGN_MASK = ~(REGSZ'(3));

   redir_state_e     state_q, state_d;
   logic [REGSZ-1:0] redirect_pc_q, redirect_pc_d;
   logic [GENW-1:0]  cur_gen_q, cur_gen_d;
   logic [15:0]      redirect_count_q, redirect_count_d;

   logic [REGSZ-1:0] br_dest;
   logic             live;

   execute_br_dest #(
      .REGSZ_P (REGSZ)
   ) u_br_dest (
      .clk         (clk),
      .brdest_op   (brdest_op),
      .op_a        (op_a),
      .op_c        (op_c),
      .pc          (pc),
      .inst_aa     (inst_aa),
      .input_valid (input_valid),
      .br_dest     (br_dest)
   );

   // Wrong-path detection and EXE hold; annul is independent of the stall.
   always_comb begin
      annul     = input_valid && (in_gen != cur_gen_q);
      exe_stall = (state_q == ST_REQ) && input_valid && !annul;
      live      = input_valid && !annul && !exe_stall;
   end

   // Next-state: exception beats everything, then taken branch, then ack.
   always_comb begin
      state_d          = state_q;
      redirect_pc_d    = redirect_pc_q;
      cur_gen_d        = cur_gen_q;
      redirect_count_d = redirect_count_q;

      if (exc_valid) begin
         // Overwrites a pending target even when acked this cycle: the old
         // request is treated as consumed and the new one follows.
         state_d          = ST_REQ;
         redirect_pc_d    = exc_vector & ALIGN_MASK;
         cur_gen_d        = cur_gen_q + 1'b1;
         redirect_count_d = redirect_count_q + 16'd1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (live && br_taken) begin
                  state_d          = ST_REQ;
                  redirect_pc_d    = br_dest;
                  cur_gen_d        = cur_gen_q + 1'b1;
                  redirect_count_d = redirect_count_q + 16'd1;
               end
            end
            ST_REQ: begin
               if (redirect_ack) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         redirect_pc_q    <= '0;
         cur_gen_q        <= '0;
         redirect_count_q <= '0;
      end else begin
         state_q          <= state_d;
         redirect_pc_q    <= redirect_pc_d;
         cur_gen_q        <= cur_gen_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   // Outputs come straight from registered state.
   always_comb begin
      redirect_valid = (state_q == ST_REQ);
      redirect_pc    = redirect_pc_q;
      cur_gen        = cur_gen_q;
      redirect_count = redirect_count_q;
   end

`ifdef SIM
   // A live taken branch must name a destination.
   always @(posedge clk) begin
      if (!reset && live && br_taken && (brdest_op == EXOP_BR_DEST_NONE)) begin
         $fatal(1, "execute_br_redirect: taken branch with brdest_op==0");
      end
   end
`endif

endmodule : execute_br_redirect

// File: tb/tb_execute_br_redirect.sv
// Directed bench for execute_br_redirect: a cycle-level reference model plus
// a per-cycle compare process, and literal expectations along the sequence.
module tb_execute_br_redirect;

   logic        clk = 1'b0;
   logic        reset;
   logic        input_valid;
   logic [1:0]  in_gen;
   logic [1:0]  brdest_op;
   logic [31:0] op_a, op_c, pc;
   logic        inst_aa, br_taken, exc_valid;
   logic [31:0] exc_vector;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ack;
   logic [1:0]  cur_gen;
   logic        exe_stall, annul;
   logic [15:0] redirect_count;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model state.
   logic        m_valid;
   logic [31:0] m_pc;
   logic [1:0]  m_gen;
   logic [15:0] m_count;

   always #5 clk = ~clk;

   execute_br_redirect #(
      .REGSZ (32),
      .GENW  (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .input_valid    (input_valid),
      .in_gen         (in_gen),
      .brdest_op      (brdest_op),
      .op_a           (op_a),
      .op_c           (op_c),
      .pc             (pc),
      .inst_aa        (inst_aa),
      .br_taken       (br_taken),
      .exc_valid      (exc_valid),
      .exc_vector     (exc_vector),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ack   (redirect_ack),
      .cur_gen        (cur_gen),
      .exe_stall      (exe_stall),
      .annul          (annul),
      .redirect_count (redirect_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] target_of(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] c, input logic [31:0] p,
                                             input logic aa);
      logic [31:0] t;
      case (op)
         2'd1:    t = a;
         2'd2:    t = c;
         2'd3:    t = aa ? a : p + a;
         default: t = 32'h0;
      endcase
      return {t[31:2], 2'b00};
   endfunction

   // Model: one redirect at most per cycle, exception first.
   always @(posedge clk) begin : model
      logic stale, hold, go;
      if (reset) begin
         m_valid = 1'b0; m_pc = 32'h0; m_gen = 2'd0; m_count = 16'd0;
      end else begin
         stale = input_valid && (in_gen != m_gen);
         hold  = m_valid && input_valid && !stale;
         go    = input_valid && !stale && !hold;
         if (exc_valid) begin
            m_valid = 1'b1;
            m_pc    = {exc_vector[31:2], 2'b00};
            m_gen   = m_gen + 2'd1;
            m_count = m_count + 16'd1;
         end else if (!m_valid && go && br_taken) begin
            m_valid = 1'b1;
            m_pc    = target_of(brdest_op, op_a, op_c, pc, inst_aa);
            m_gen   = m_gen + 2'd1;
            m_count = m_count + 16'd1;
         end else if (m_valid && redirect_ack) begin
            m_valid = 1'b0;
         end
      end
   end

   // Compare every cycle once the design has been reset.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_redirect_valid", {31'b0, redirect_valid}, {31'b0, m_valid});
         chk("model_redirect_pc", redirect_pc, m_pc);
         chk("model_cur_gen", {30'b0, cur_gen}, {30'b0, m_gen});
         chk("model_redirect_count", {16'b0, redirect_count}, {16'b0, m_count});
         chk("model_annul", {31'b0, annul}, {31'b0, input_valid && (in_gen != m_gen)});
         chk("model_exe_stall", {31'b0, exe_stall},
             {31'b0, m_valid && input_valid && (in_gen == m_gen)});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_branch(input logic [1:0] g, input logic [1:0] op, input logic [31:0] p,
                               input logic [31:0] a, input logic [31:0] c, input logic aa,
                               input logic taken);
      input_valid = 1'b1; in_gen = g; brdest_op = op; pc = p; op_a = a; op_c = c;
      inst_aa = aa; br_taken = taken;
      cyc();
      input_valid = 1'b0; br_taken = 1'b0; brdest_op = 2'd0;
   endtask

   task automatic do_ack();
      redirect_ack = 1'b1;
      cyc();
      redirect_ack = 1'b0;
   endtask

   task automatic expect_state(input string tag, input logic v, input logic [31:0] p,
                               input logic [1:0] g, input logic [15:0] n);
      chk({tag, "_valid"}, {31'b0, redirect_valid}, {31'b0, v});
      chk({tag, "_pc"}, redirect_pc, p);
      chk({tag, "_gen"}, {30'b0, cur_gen}, {30'b0, g});
      chk({tag, "_count"}, {16'b0, redirect_count}, {16'b0, n});
   endtask

   initial begin
      reset = 1'b1; input_valid = 1'b0; in_gen = 2'd0; brdest_op = 2'd0;
      op_a = '0; op_c = '0; pc = '0; inst_aa = 1'b0; br_taken = 1'b0;
      exc_valid = 1'b0; exc_vector = '0; redirect_ack = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      reset = 1'b0;
      expect_state("reset", 1'b0, 32'h0, 2'd0, 16'd0);

      // Relative branch, held for three cycles, then acked.
      issue_branch(2'd0, 2'd3, 32'h1000, 32'h20, 32'h0, 1'b0, 1'b1);
      expect_state("rel", 1'b1, 32'h1020, 2'd1, 16'd1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("rel_hold_pc", redirect_pc, 32'h1020);
         chk("rel_hold_valid", {31'b0, redirect_valid}, 32'd1);
      end
      do_ack();
      chk("rel_ack_idle", {31'b0, redirect_valid}, 32'd0);

      // LR branch with misaligned operand.
      issue_branch(2'd1, 2'd2, 32'h1020, 32'h0, 32'h2003, 1'b0, 1'b1);
      expect_state("lr", 1'b1, 32'h2000, 2'd2, 16'd2);
      do_ack();

      // Not-taken branch.
      issue_branch(2'd2, 2'd3, 32'h2000, 32'h40, 32'h0, 1'b0, 1'b0);
      expect_state("nt", 1'b0, 32'h2000, 2'd2, 16'd2);

      // Absolute branch via AA bit.
      issue_branch(2'd2, 2'd3, 32'h2000, 32'h3007, 32'h0, 1'b1, 1'b1);
      expect_state("abs", 1'b1, 32'h3004, 2'd3, 16'd3);
      do_ack();

      // Wrong-path instruction is annulled and redirects nothing.
      input_valid = 1'b1; in_gen = 2'd0; brdest_op = 2'd3; pc = 32'h5000;
      op_a = 32'h100; br_taken = 1'b1;
      #1;
      chk("wp_annul", {31'b0, annul}, 32'd1);
      chk("wp_stall", {31'b0, exe_stall}, 32'd0);
      cyc();
      input_valid = 1'b0; br_taken = 1'b0;
      expect_state("wp", 1'b0, 32'h3004, 2'd3, 16'd3);

      // Fourth redirect wraps the generation back to zero.
      issue_branch(2'd3, 2'd1, 32'h0, 32'h4002, 32'h0, 1'b0, 1'b1);
      expect_state("genwrap", 1'b1, 32'h4000, 2'd0, 16'd4);

      // Current-generation instruction stalls while a redirect is pending.
      input_valid = 1'b1; in_gen = 2'd0; brdest_op = 2'd3; pc = 32'h6000;
      op_a = 32'h8; inst_aa = 1'b0; br_taken = 1'b1;
      #1;
      chk("req_stall", {31'b0, exe_stall}, 32'd1);
      chk("req_annul", {31'b0, annul}, 32'd0);
      cyc();
      expect_state("req_hold", 1'b1, 32'h4000, 2'd0, 16'd4);
      in_gen = 2'd3;
      #1;
      chk("req_stale_annul", {31'b0, annul}, 32'd1);
      chk("req_stale_stall", {31'b0, exe_stall}, 32'd0);
      input_valid = 1'b0; br_taken = 1'b0;
      do_ack();
      chk("req_ack_idle", {31'b0, redirect_valid}, 32'd0);

      // Exception beats a simultaneous taken branch.
      exc_valid = 1'b1; exc_vector = 32'h700;
      issue_branch(2'd0, 2'd3, 32'h1000, 32'h20, 32'h0, 1'b0, 1'b1);
      exc_valid = 1'b0;
      expect_state("exc_prio", 1'b1, 32'h700, 2'd1, 16'd5);

      // Exception overwrites a pending request acked the same cycle.
      exc_valid = 1'b1; exc_vector = 32'h903; redirect_ack = 1'b1;
      cyc();
      exc_valid = 1'b0; redirect_ack = 1'b0;
      expect_state("exc_ovr", 1'b1, 32'h900, 2'd2, 16'd6);
      do_ack();
      chk("exc_ack_idle", {31'b0, redirect_valid}, 32'd0);

      // Ack while idle is ignored.
      do_ack();
      expect_state("idle_ack", 1'b0, 32'h900, 2'd2, 16'd6);

      // Reset while a redirect is pending.
      exc_valid = 1'b1; exc_vector = 32'h500;
      cyc();
      exc_valid = 1'b0;
      chk("pre_rst_valid", {31'b0, redirect_valid}, 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      expect_state("rst_req", 1'b0, 32'h0, 2'd0, 16'd0);

      // 65536 redirects from reset wrap the counter back to zero.
      exc_valid = 1'b1; exc_vector = 32'h504;
      repeat (65536) cyc();
      exc_valid = 1'b0;
      expect_state("cntwrap", 1'b1, 32'h504, 2'd0, 16'd0);
      do_ack();
      chk("final_idle", {31'b0, redirect_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_execute_br_redirect
